// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply (shift-add, LSB-first) and restoring divide (MSB-first).
// Results are registered and held from completion until the next accepted operation finishes.
module muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_zero
);
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam int         CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;       // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   opb_q, opb_d;       // multiplier (shifted right), or divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               overflow_q, overflow_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic               last_iter;

    // One iteration of each datapath; the FSM picks which one commits.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
        mul_acc   = opb_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        div_shift = {rem_q, opa_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opb_q};
        div_ok    = ~div_trial[WIDTH+1];
        div_rem   = div_ok ? WIDTH'(div_trial) : WIDTH'(div_shift);
        div_quo   = {opa_q[WIDTH-2:0], div_ok};
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            S_IDLE: begin
                if (start && (opcode == OP_MUL || opcode == OP_DIV)) begin
                    opa_d = a_in;
                    opb_d = d_in;
                    acc_d = '0;
                    rem_d = '0;
                    cnt_d = '0;
                    if (opcode == OP_MUL) begin
                        state_d = S_MUL;
                    end else if (d_in == '0) begin
                        result_d    = '1;
                        result_hi_d = '0;
                        remainder_d = a_in;
                        overflow_d  = 1'b0;
                        div_zero_d  = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d    = mul_acc[WIDTH-1:0];
                    result_hi_d = mul_acc[2*WIDTH-1:WIDTH];
                    overflow_d  = |mul_acc[2*WIDTH-1:WIDTH];
                    remainder_d = '0;
                    div_zero_d  = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DIV: begin
                rem_d = div_rem;
                opa_d = div_quo;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d    = div_quo;
                    remainder_d = div_rem;
                    result_hi_d = '0;
                    overflow_d  = 1'b0;
                    div_zero_d  = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign remainder = remainder_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model checked every cycle,
// plus hand-computed literal checks at each completion.
module tb_muldiv_unit;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] opcode;
    logic [7:0] a_in, d_in;
    logic       busy, done, overflow, div_zero;
    logic [7:0] result, result_hi, remainder;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .a_in(a_in), .d_in(d_in), .busy(busy), .done(done),
        .result(result), .result_hi(result_hi), .remainder(remainder),
        .overflow(overflow), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..8 = iterating, 9 = done cycle.
    int         m_t;
    logic [7:0] m_res, m_hi, m_rem, p_res, p_hi, p_rem;
    logic       m_ov, m_dz, p_ov;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t   <= 0;
            m_res <= '0; m_hi <= '0; m_rem <= '0; m_ov <= 1'b0; m_dz <= 1'b0;
        end else if (m_t == 0) begin
            if (start && opcode == OP_MUL) begin
                {p_hi, p_res} <= {8'd0, a_in} * {8'd0, d_in};
                p_ov  <= (({8'd0, a_in} * {8'd0, d_in}) > 16'd255);
                p_rem <= '0;
                m_t   <= 1;
            end else if (start && opcode == OP_DIV) begin
                if (d_in == 8'd0) begin
                    m_res <= 8'hFF; m_hi <= '0; m_rem <= a_in; m_ov <= 1'b0; m_dz <= 1'b1;
                    m_t   <= 9;
                end else begin
                    p_res <= a_in / d_in;
                    p_rem <= a_in % d_in;
                    p_hi  <= '0;
                    p_ov  <= 1'b0;
                    m_t   <= 1;
                end
            end
        end else if (m_t == 9) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == 8) begin
                m_res <= p_res; m_hi <= p_hi; m_rem <= p_rem; m_ov <= p_ov; m_dz <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle", {7'd0, busy, done, result, result_hi, remainder, overflow, div_zero},
            {7'd0, (m_t >= 1 && m_t <= 8), (m_t == 9), m_res, m_hi, m_rem, m_ov, m_dz});
    end

    // Issues one request and waits (bounded) for done; lat counts negedges after the start edge.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                          input int exp_lat, input string name);
        int k;
        @(negedge clk);
        start = 1'b1; opcode = op; a_in = a; d_in = d;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                a_in  = 8'($urandom);
                d_in  = 8'($urandom);
            end
            if (done) break;
        end
        chk({name, "_lat"}, k, exp_lat);
    endtask

    initial begin
        int ndone;
        reset = 1'b0; start = 1'b0; opcode = 4'd0; a_in = '0; d_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, result, result_hi, remainder, overflow, div_zero}, 0);
        reset = 1'b1;

        run_op(OP_MUL, 8'd13, 8'd11, 9, "mul13x11");
        chk("mul13x11_res", {result_hi, result, 7'd0, overflow}, {8'h00, 8'h8F, 8'd0});

        run_op(OP_MUL, 8'd200, 8'd200, 9, "mul200x200");
        chk("mul200x200_res", {result_hi, result, 7'd0, overflow}, {8'h9C, 8'h40, 8'd1});
        repeat (5) @(negedge clk);
        chk("mul_hold", result, 8'h40);

        run_op(OP_DIV, 8'd200, 8'd7, 9, "div200by7");
        chk("div200by7_res", {result, remainder, result_hi, 7'd0, div_zero}, {8'h1C, 8'h04, 8'h00, 8'd0});
        run_op(OP_DIV, 8'd255, 8'd1, 9, "div255by1");
        chk("div255by1_res", {result, remainder}, {8'hFF, 8'h00});
        run_op(OP_DIV, 8'd3, 8'd9, 9, "div3by9");
        chk("div3by9_res", {result, remainder}, {8'h00, 8'h03});

        run_op(OP_DIV, 8'd5, 8'd0, 1, "div0");
        chk("div0_res", {result, remainder, 6'd0, busy, div_zero}, {8'hFF, 8'h05, 8'd1});

        // Unsupported opcode: no activity, outputs unchanged.
        @(negedge clk);
        start = 1'b1; opcode = 4'b0010; a_in = 8'd1; d_in = 8'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("badop_activity", ndone, 0);
        chk("badop_hold", {result, remainder}, {8'hFF, 8'h05});

        // Second request while busy is dropped.
        @(negedge clk);
        start = 1'b1; opcode = OP_DIV; a_in = 8'd6; d_in = 8'd2;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; opcode = OP_MUL; a_in = 8'd9; d_in = 8'd9; end
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                chk("busy_drop_res", {result, remainder}, {8'd3, 8'd0});
            end
        end
        chk("busy_drop_count", ndone, 1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; opcode = OP_MUL; a_in = 8'd13; d_in = 8'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("async_rst", {busy, done, result, result_hi, remainder, overflow, div_zero}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 0);

        run_op(OP_MUL, 8'd2, 8'd3, 9, "mul2x3");
        chk("mul2x3_res", {result_hi, result}, {8'd0, 8'd6});

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
